kf6845_vram_arbiter: RTL and testbench

//  Shares a single-port synchronous video RAM between the KF6845 refresh stream (MA/RA/DE) and a CPU port.
//  For each displayed character it fetches the character and attribute bytes, then double-buffers them.
//  The pixel pipeline therefore sees a stable pair for a whole character period.
//  CPU reads and writes are served in cycles the refresh stream leaves free; refresh always has priority.

---
 rtl/kf6845_vram_pkg.sv | 30 +++
 rtl/kf6845_fetch_buffer.sv | 40 ++++
 rtl/kf6845_vram_arbiter.sv | 126 ++++++++++++
 tb/tb_kf6845_vram_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf6845_vram_pkg.sv
// Shared types and helpers for the KF6845 video RAM arbiter.
// Holds the FSM encoding, slot timing constants and the fetch address builder.
package kf6845_vram_pkg;

  localparam int VRAM_AW       = 14;
  localparam int MIN_CHAR_CLKS = 6;
  localparam int FETCH_CLKS    = 3;
  localparam int CPU_CLKS      = 2;

  typedef enum logic [2:0] {
    IDLE,
    F_CHAR,
    F_ATTR,
    F_CAP,
    C_ISSUE,
    C_DONE
  } arb_state_t;

  // Graphics mode interleaves two RA-selected banks; text mode packs MA straight in.
  // Dropping the top bit of {MA, byte} gives the mod 2^VRAM_AW wrap.
  function automatic logic [VRAM_AW-1:0] fetch_addr(
    input logic [12:0] ma,
    input logic        ra0,
    input logic        gfx,
    input logic        attr_byte
  );
    return gfx ? {ra0, ma[11:0], attr_byte} : {ma, attr_byte};
  endfunction

endpackage

// File: rtl/kf6845_fetch_buffer.sv
// Double buffer for one character/attribute pair: back fills during a slot, front feeds pixels.
// Latency: swap visible the cycle after the strobe; no backpressure, loads are unconditional.
// Blank forces the back pair to zero for slots where nothing is displayed.
module kf6845_fetch_buffer (
  input  logic       clock,
  input  logic       reset,
  input  logic       swap,
  input  logic       blank,
  input  logic       load_char,
  input  logic       load_attr,
  input  logic [7:0] rdata,
  output logic [7:0] char_code,
  output logic [7:0] char_attr
);

  logic [7:0] back_char;
  logic [7:0] back_attr;

  always_ff @(posedge clock) begin
    if (reset) begin
      back_char <= '0;
      back_attr <= '0;
      char_code <= '0;
      char_attr <= '0;
    end else begin
      if (swap) begin
        char_code <= back_char;
        char_attr <= back_attr;
      end
      if (blank) begin
        back_char <= '0;
        back_attr <= '0;
      end else begin
        if (load_char) back_char <= rdata;
        if (load_attr) back_attr <= rdata;
      end
    end
  end

endmodule

// File: rtl/kf6845_vram_arbiter.sv
// Shares one synchronous VRAM between CRTC refresh fetches and a CPU port.
// Latency: fetch 3 cycles, CPU access 2 cycles (ack in C_DONE).
// Backpressure: refresh has priority; cpu_req is held until cpu_ack.
module kf6845_vram_arbiter
  import kf6845_vram_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               video_clock_enable,
  input  logic               DE,
  input  logic [13:0]        MA,
  input  logic [4:0]         RA,
  input  logic               graphics_mode,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  output logic [7:0]         char_code,
  output logic [7:0]         char_attr
);

  arb_state_t         state, state_nxt;
  logic               fetch_pend;
  logic               slot_overrun;
  logic [12:0]        ma_q;
  logic               ra0_q;
  logic               gfx_q;
  logic               we_q;
  logic [VRAM_AW-1:0] addr_q;
  logic [7:0]         rdata_q;
  logic               slot_start;
  logic               fetch_start;
  logic               unused_crtc_bits;

  assign unused_crtc_bits = ^{MA[13], RA[4:1]};

  // A strobe while the previous fetch is still pending is dropped entirely.
  assign slot_start  = video_clock_enable && !fetch_pend;
  assign fetch_start = slot_start && DE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      fetch_pend   <= 1'b0;
      slot_overrun <= 1'b0;
      ma_q         <= '0;
      ra0_q        <= 1'b0;
      gfx_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= vram_addr;
      if (fetch_start) begin
        fetch_pend <= 1'b1;
        ma_q       <= MA[12:0];
        ra0_q      <= RA[0];
        gfx_q      <= graphics_mode;
      end else if (state == F_CAP) begin
        fetch_pend <= 1'b0;
      end
      if (video_clock_enable && fetch_pend) slot_overrun <= 1'b1;
      if (state == C_ISSUE) we_q <= cpu_we;
      if (state == C_DONE && !we_q) rdata_q <= vram_rdata;
    end
  end

  // fetch_start is checked alongside fetch_pend so a same-cycle cpu_req loses the tie.
  always_comb begin
    state_nxt  = state;
    vram_addr  = addr_q;
    vram_we    = 1'b0;
    vram_wdata = '0;
    cpu_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_pend || fetch_start) state_nxt = F_CHAR;
        else if (cpu_req)              state_nxt = C_ISSUE;
      end
      F_CHAR: begin
        vram_addr = fetch_addr(ma_q, ra0_q, gfx_q, 1'b0);
        state_nxt = F_ATTR;
      end
      F_ATTR: begin
        vram_addr = fetch_addr(ma_q, ra0_q, gfx_q, 1'b1);
        state_nxt = F_CAP;
      end
      F_CAP: state_nxt = IDLE;
      C_ISSUE: begin
        vram_addr  = cpu_addr;
        vram_we    = cpu_we;
        vram_wdata = cpu_wdata;
        state_nxt  = C_DONE;
      end
      C_DONE: begin
        cpu_ack   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_rdata = (state == C_DONE && !we_q) ? vram_rdata : rdata_q;

  kf6845_fetch_buffer u_fetch_buffer (
    .clock     (clock),
    .reset     (reset),
    .swap      (slot_start),
    .blank     (slot_start && !DE),
    .load_char (state == F_ATTR),
    .load_attr (state == F_CAP),
    .rdata     (vram_rdata),
    .char_code (char_code),
    .char_attr (char_attr)
  );

  a_no_slot_overrun: assert property (@(posedge clock) disable iff (reset) !slot_overrun);

endmodule

// File: tb/tb_kf6845_vram_arbiter.sv
// Directed bench for kf6845_vram_arbiter with a behavioural 1-cycle-latency VRAM.
// Character pairs and CPU read data are queued when stimulus is driven and checked when produced.
module tb_kf6845_vram_arbiter;
  import kf6845_vram_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        vce;
  logic        de;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        gfx;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [7:0]  char_code;
  logic [7:0]  char_attr;

  always #5 clock = ~clock;

  kf6845_vram_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .video_clock_enable (vce),
    .DE                 (de),
    .MA                 (ma),
    .RA                 (ra),
    .graphics_mode      (gfx),
    .cpu_req            (cpu_req),
    .cpu_we             (cpu_we),
    .cpu_addr           (cpu_addr),
    .cpu_wdata          (cpu_wdata),
    .cpu_ack            (cpu_ack),
    .cpu_rdata          (cpu_rdata),
    .vram_addr          (vram_addr),
    .vram_we            (vram_we),
    .vram_wdata         (vram_wdata),
    .vram_rdata         (vram_rdata),
    .char_code          (char_code),
    .char_attr          (char_attr)
  );

  // Power-on RAM contents: fixed bytes for the text-mode character, a hash elsewhere.
  function automatic logic [7:0] pat(input int a);
    if (a == 32'h246) return 8'h41;
    if (a == 32'h247) return 8'h1F;
    return 8'((a ^ (a >> 6) ^ 32'h3C) & 32'hFF);
  endfunction

  logic [7:0] ram_mem [16384];
  bit         ram_wr  [16384];

  always @(posedge clock) begin
    if (vram_we) begin
      ram_mem[vram_addr] <= vram_wdata;
      ram_wr[vram_addr]  <= 1'b1;
    end
    vram_rdata <= ram_wr[vram_addr] ? ram_mem[vram_addr] : pat(int'(vram_addr));
  end

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_stb = -100;
  int         t0 = 0;
  bit         op_active = 1'b0;
  bit         ack_seen = 1'b0;
  bit         cur_read = 1'b0;
  logic [7:0] rd_q [$];
  logic [15:0] pair_q [$];
  logic [7:0] shadow [int];

  function automatic int fa(input logic [13:0] m, input logic [4:0] r, input logic g, input int hi);
    if (g) return ((int'(r) & 1) << 13) | ((int'(m) & 32'hFFF) << 1) | hi;
    return ((int'(m) << 1) | hi) % 16384;
  endfunction

  function automatic logic [7:0] exp_byte(input int a);
    if (shadow.exists(a)) return shadow[a];
    return pat(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (cpu_ack === 1'b1) begin
      if (!op_active) begin
        check("spurious_ack", {31'b0, cpu_ack}, 32'd0);
      end else begin
        ack_seen  = 1'b1;
        op_active = 1'b0;
        cpu_req   = 1'b0;
        if (cur_read) check("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, rd_q.pop_front()});
      end
    end
  endtask

  task automatic cpu_start(input logic we, input logic [13:0] a, input logic [7:0] d);
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_req   = 1'b1;
    op_active = 1'b1;
    ack_seen  = 1'b0;
    cur_read  = !we;
    t0        = cyc;
    if (we) shadow[int'(a)] = d;
    else    rd_q.push_back(exp_byte(int'(a)));
  endtask

  task automatic cpu_wait(input int lat);
    while (!ack_seen && cyc - t0 < 20) step();
    if (ack_seen) check("ack_latency", cyc - t0, lat);
    else          check("ack_timeout", {31'b0, ack_seen}, 32'd1);
  endtask

  task automatic wait_gap();
    while (cyc - last_stb < 8) step();
  endtask

  task automatic stb(input logic d);
    logic [15:0] p;
    vce = 1'b1;
    de  = d;
    step();
    vce      = 1'b0;
    last_stb = cyc;
    if (pair_q.size() > 0) begin
      p = pair_q.pop_front();
      check("char_code", {24'b0, char_code}, {24'b0, p[15:8]});
      check("char_attr", {24'b0, char_attr}, {24'b0, p[7:0]});
    end
    if (d) pair_q.push_back({exp_byte(fa(ma, ra, gfx, 0)), exp_byte(fa(ma, ra, gfx, 1))});
    else   pair_q.push_back(16'h0000);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_char_code"}, {24'b0, char_code}, 32'd0);
    check({tag, "_char_attr"}, {24'b0, char_attr}, 32'd0);
    check({tag, "_vram_addr"}, {18'b0, vram_addr}, 32'd0);
    check({tag, "_vram_we"}, {31'b0, vram_we}, 32'd0);
    check({tag, "_vram_wdata"}, {24'b0, vram_wdata}, 32'd0);
    check({tag, "_cpu_ack"}, {31'b0, cpu_ack}, 32'd0);
    check({tag, "_cpu_rdata"}, {24'b0, cpu_rdata}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; vce = 1'b0; de = 1'b0; ma = '0; ra = '0; gfx = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    pair_q.push_back(16'h0000);

    // Text mode fetch of MA=0x123, visible one character period later.
    ma = 14'h0123;
    wait_gap();
    stb(1'b1);
    check("t1_char_addr", {18'b0, vram_addr}, 32'h246);
    step();
    check("t1_attr_addr", {18'b0, vram_addr}, 32'h247);
    wait_gap();
    stb(1'b1);
    repeat (3) step();

    // CPU write then read-back at the top of memory.
    cpu_start(1'b1, 14'h3FFF, 8'hA5);
    step();
    check("t2_we", {31'b0, vram_we}, 32'd1);
    check("t2_addr", {18'b0, vram_addr}, 32'h3FFF);
    check("t2_wdata", {24'b0, vram_wdata}, 32'hA5);
    cpu_wait(2);
    step();
    check("t2_we_low", {31'b0, vram_we}, 32'd0);
    check("t2_addr_hold", {18'b0, vram_addr}, 32'h3FFF);
    cpu_start(1'b0, 14'h3FFF, 8'h00);
    cpu_wait(2);
    repeat (2) step();
    check("t2_rdata_held", {24'b0, cpu_rdata}, 32'hA5);

    // Strobe and CPU request together: fetch first, ack five cycles after the fetch issues.
    ma = 14'h0200;
    wait_gap();
    cpu_start(1'b0, 14'h0010, 8'h00);
    stb(1'b1);
    check("t3_fetch_first", {18'b0, vram_addr}, 32'h400);
    cpu_wait(6);

    // DE low: blank slot, pending CPU read served straight away.
    wait_gap();
    cpu_start(1'b0, 14'h0247, 8'h00);
    stb(1'b0);
    check("t4_cpu_immediate", {18'b0, vram_addr}, 32'h247);
    check("t4_no_write", {31'b0, vram_we}, 32'd0);
    cpu_wait(2);

    // Graphics addressing and text-mode wrap at the top of memory.
    gfx = 1'b1; ra = 5'd1; ma = 14'h0FFF;
    wait_gap();
    stb(1'b1);
    check("t5_gfx_char", {18'b0, vram_addr}, 32'h3FFE);
    step();
    check("t5_gfx_attr", {18'b0, vram_addr}, 32'h3FFF);
    gfx = 1'b0; ra = 5'd0; ma = 14'h1FFF;
    wait_gap();
    stb(1'b1);
    check("t5_wrap_char", {18'b0, vram_addr}, 32'h3FFE);
    step();
    check("t5_wrap_attr", {18'b0, vram_addr}, 32'h3FFF);
    repeat (3) step();

    // Reset while a CPU read is in C_ISSUE: the access is dropped without ack.
    cpu_start(1'b0, 14'h0246, 8'h00);
    step();
    check("t6_issue_addr", {18'b0, vram_addr}, 32'h246);
    reset = 1'b1;
    step();
    check_all_zero("t6_reset");
    cpu_req = 1'b0;
    op_active = 1'b0;
    rd_q.delete();
    pair_q.delete();
    pair_q.push_back(16'h0000);
    step();
    reset = 1'b0;
    ma = 14'h0123;
    wait_gap();
    stb(1'b1);
    repeat (3) step();
    cpu_start(1'b0, 14'h3FFF, 8'h00);
    cpu_wait(2);
    wait_gap();
    stb(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
